// File: rtl/sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module      : sequential_divider
//  Description : Multi-cycle restoring divider (shift-and-subtract), one
//                quotient bit per cycle, unsigned or two's-complement signed.
//                Start/done handshake; fixed latency of WIDTH+1 clock edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module sequential_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             operation,
  input  logic [WIDTH-1:0] lhs,
  input  logic [WIDTH-1:0] rhs,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int             CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST     = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL1   = '1;
  localparam logic [WIDTH-1:0] MOSTNEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dividend;   // dividend magnitude, shifted out MSB first
  logic [WIDTH-1:0] divisor;    // divisor magnitude
  logic [WIDTH-1:0] prem;       // partial remainder
  logic [WIDTH-1:0] quo;        // quotient magnitude being assembled
  logic [WIDTH-1:0] lhs_raw;    // original dividend, returned on divide-by-zero
  logic             neg_q;
  logic             neg_r;
  logic             zero_flag;
  logic             ovf_flag;

  // Operand sign/magnitude extraction; signs only matter for signed divides.
  logic             lhs_neg;
  logic             rhs_neg;
  logic [WIDTH-1:0] lhs_mag;
  logic [WIDTH-1:0] rhs_mag;
  assign lhs_neg = operation & lhs[WIDTH-1];
  assign rhs_neg = operation & rhs[WIDTH-1];
  assign lhs_mag = lhs_neg ? ((~lhs) + ONE) : lhs;
  assign rhs_mag = rhs_neg ? ((~rhs) + ONE) : rhs;

  // Trial subtraction one bit wider than the operands; MSB set means negative.
  logic [WIDTH:0]   trial;
  assign trial = {prem, dividend[WIDTH-1]} - {1'b0, divisor};

  // Sign-corrected results applied in FIX.
  logic [WIDTH-1:0] q_signed;
  logic [WIDTH-1:0] r_signed;
  assign q_signed = neg_q ? ((~quo) + ONE) : quo;
  assign r_signed = neg_r ? ((~prem) + ONE) : prem;

  // Control FSM and datapath: capture, iterate one bit per cycle, fix up signs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      dividend    <= '0;
      divisor     <= '0;
      prem        <= '0;
      quo         <= '0;
      lhs_raw     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_flag   <= 1'b0;
      ovf_flag    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            dividend  <= lhs_mag;
            divisor   <= rhs_mag;
            lhs_raw   <= lhs;
            neg_q     <= lhs_neg ^ rhs_neg;
            neg_r     <= lhs_neg;
            zero_flag <= (rhs == '0);
            ovf_flag  <= operation && (lhs == MOSTNEG) && (rhs == ALL1);
            prem      <= '0;
            quo       <= '0;
            count     <= LAST;
            busy      <= 1'b1;
            state     <= CALC;
          end
        end

        CALC: begin
          dividend <= dividend << 1;
          if (!trial[WIDTH]) begin
            prem <= trial[WIDTH-1:0];
            quo  <= {quo[WIDTH-2:0], 1'b1};
          end else begin
            // Restore: shifted remainder is below the divisor, so it fits WIDTH bits.
            prem <= {prem[WIDTH-2:0], dividend[WIDTH-1]};
            quo  <= {quo[WIDTH-2:0], 1'b0};
          end
          if (count == '0) begin
            state <= FIX;
          end else begin
            count <= count - CW'(1);
          end
        end

        FIX: begin
          if (zero_flag) begin
            quotient  <= ALL1;
            remainder <= lhs_raw;
          end else if (ovf_flag) begin
            quotient  <= lhs_raw;
            remainder <= '0;
          end else begin
            quotient  <= q_signed;
            remainder <= r_signed;
          end
          div_by_zero <= zero_flag;
          overflow    <= ovf_flag & ~zero_flag;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sequential_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sequential_divider
//  Description : Directed + light random bench for sequential_divider with a
//                result scoreboard and an independent arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sequential_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic         operation;
  logic [W-1:0] lhs;
  logic [W-1:0] rhs;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int t0     = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    logic         ov;
  } res_t;

  res_t sb[$];

  sequential_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .lhs(lhs), .rhs(rhs), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Edge counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic res_t model(input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    res_t e;
    int   sa;
    int   sb_;
    e = '0;
    if (b == '0) begin
      e.q  = '1;
      e.r  = a;
      e.dz = 1'b1;
    end else if (op && a == 4'b1000 && b == 4'b1111) begin
      e.q  = a;
      e.r  = '0;
      e.ov = 1'b1;
    end else if (op) begin
      sa   = $signed(a);
      sb_  = $signed(b);
      e.q  = W'(sa / sb_);
      e.r  = W'(sa % sb_);
    end else begin
      e.q  = a / b;
      e.r  = a % b;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; optionally record the expected result.
  task automatic launch(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    @(negedge clk);
    start = 1'b1; operation = op; lhs = a; rhs = b;
    if (push) sb.push_back(model(op, a, b));
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("busy_after_start", busy, 1);
  endtask

  // Wait (bounded) for done, then check latency and pop/compare the scoreboard.
  task automatic wait_done(input string tag);
    int   k;
    bit   seen;
    res_t e;
    k = 0; seen = 0;
    while (k < 30 && !seen) begin
      if (done === 1'b1) seen = 1;
      else begin
        @(negedge clk);
        k++;
      end
    end
    check({tag, "_done_seen"}, seen, 1);
    if (seen) begin
      check({tag, "_latency"}, cyc - t0, W + 1);
      check({tag, "_busy_low"}, busy, 0);
      if (sb.size() == 0) begin
        check({tag, "_sb_nonempty"}, 0, 1);
      end else begin
        e = sb.pop_front();
        check({tag, "_quotient"}, quotient, e.q);
        check({tag, "_remainder"}, remainder, e.r);
        check({tag, "_div_by_zero"}, div_by_zero, e.dz);
        check({tag, "_overflow"}, overflow, e.ov);
      end
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [W-1:0] a, input logic [W-1:0] b);
    launch(op, a, b, 1);
    wait_done(tag);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    logic [W-1:0] hq;
    bit           any_done;
    reset = 1'b1; start = 1'b0; operation = 1'b0; lhs = '0; rhs = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_flags", {div_by_zero, overflow}, 0);
    reset = 1'b0;

    // Main function, boundary cases
    run_op("u13_3",   1'b0, 4'b1101, 4'b0011);
    run_op("s-7_2",   1'b1, 4'b1001, 4'b0010);
    run_op("u9_0",    1'b0, 4'd9,    4'd0);
    run_op("s-3_0",   1'b1, 4'b1101, 4'd0);
    run_op("s_ovf",   1'b1, 4'b1000, 4'b1111);
    run_op("s7_-2",   1'b1, 4'b0111, 4'b1110);
    run_op("s-8_3",   1'b1, 4'b1000, 4'b0011);
    run_op("u15_1",   1'b0, 4'd15,   4'd1);

    // Outputs hold in IDLE
    hq = quotient;
    repeat (3) @(negedge clk);
    check("idle_hold_q", quotient, hq);

    // start while busy is ignored; operand changes while busy have no effect
    launch(1'b0, 4'd15, 4'd4, 1);
    @(negedge clk);
    start = 1'b1; lhs = 4'd6; rhs = 4'd2;
    @(negedge clk);
    start = 1'b0; lhs = 4'd0; rhs = 4'd0; operation = 1'b1;
    wait_done("busy_ignore");

    // start during the done cycle is accepted
    start = 1'b1; operation = 1'b0; lhs = 4'd6; rhs = 4'd2;
    sb.push_back(model(1'b0, 4'd6, 4'd2));
    @(negedge clk);
    start = 1'b0;
    t0 = cyc;
    check("b2b_done_drop", done, 0);
    check("b2b_busy", busy, 1);
    wait_done("b2b");
    @(negedge clk);

    // Reset mid-operation aborts with no done pulse
    launch(1'b0, 4'd13, 4'd3, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_outputs", {quotient, remainder, div_by_zero, overflow}, 0);
    any_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) any_done = 1;
    end
    check("abort_no_done", any_done, 0);
    run_op("after_abort_8_3", 1'b0, 4'd8, 4'd3);

    // A few random operands in both modes
    for (int i = 0; i < 8; i++) begin
      run_op("rand", 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
